// File: rtl/bsg_div_iterative_nr.sv
// Iterative non-restoring integer divider, signed or unsigned, retiring
// bits_per_iter_p quotient bits per cycle behind a ready/valid-in, valid/yumi-out handshake.
module bsg_div_iterative_nr #(
  parameter int width_p         = 64,
  parameter int bits_per_iter_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  output logic               ready_o,
  input  logic [width_p-1:0] dividend_i,
  input  logic [width_p-1:0] divisor_i,
  input  logic               signed_i,
  input  logic               v_i,
  output logic [width_p-1:0] quotient_o,
  output logic [width_p-1:0] remainder_o,
  output logic               dbz_o,
  output logic               v_o,
  input  logic               yumi_i
);

  localparam int iters_lp = width_p / bits_per_iter_p;
  localparam int cnt_w_lp = (iters_lp > 1) ? $clog2(iters_lp) : 1;
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(iters_lp - 1);

  typedef enum logic [2:0] {eIdle, ePre, eCal, eFix, eDone} state_e;

  state_e state_r, state_n;

  logic [width_p-1:0]  dvd_raw_r, dvs_raw_r;
  logic                signed_r;
  logic [width_p-1:0]  dvs_r, quo_r;
  logic [width_p:0]    rem_r;
  logic                sign_q_r, sign_r_r, dbz_r;
  logic [cnt_w_lp-1:0] cnt_r;

  logic                dvd_neg, dvs_neg;
  logic [width_p-1:0]  dvd_mag, dvs_mag;
  logic [width_p:0]    rem_step;
  logic [width_p-1:0]  quo_step;
  logic [width_p-1:0]  rem_lo, rem_fix, quo_fix;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eIdle;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    ready_o = 1'b0;
    v_o     = 1'b0;
    case (state_r)
      eIdle: begin
        ready_o = 1'b1;
        if (v_i) state_n = ePre;
      end
      ePre:  state_n = eCal;
      eCal:  if (cnt_r == last_cnt_lp) state_n = eFix;
      eFix:  state_n = eDone;
      eDone: begin
        v_o = 1'b1;
        if (yumi_i) state_n = eIdle;
      end
      default: state_n = eIdle;
    endcase
  end

  // Partial remainder is kept one bit wider than the operands; intermediate
  // wrap-around is harmless because every post-step value fits in (-dvs, dvs).
  always_comb begin
    dvd_neg  = signed_r & dvd_raw_r[width_p-1];
    dvs_neg  = signed_r & dvs_raw_r[width_p-1];
    dvd_mag  = dvd_neg ? -dvd_raw_r : dvd_raw_r;
    dvs_mag  = dvs_neg ? -dvs_raw_r : dvs_raw_r;
    rem_step = rem_r;
    quo_step = quo_r;
    for (int i = 0; i < bits_per_iter_p; i++) begin
      rem_step = rem_step[width_p]
               ? {rem_step[width_p-1:0], quo_step[width_p-1]} + {1'b0, dvs_r}
               : {rem_step[width_p-1:0], quo_step[width_p-1]} - {1'b0, dvs_r};
      quo_step = {quo_step[width_p-2:0], ~rem_step[width_p]};
    end
    rem_lo  = rem_r[width_p] ? rem_r[width_p-1:0] + dvs_r : rem_r[width_p-1:0];
    rem_fix = sign_r_r ? -rem_lo : rem_lo;
    quo_fix = sign_q_r ? -quo_r : quo_r;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      dvd_raw_r   <= '0;
      dvs_raw_r   <= '0;
      signed_r    <= 1'b0;
      dvs_r       <= '0;
      quo_r       <= '0;
      rem_r       <= '0;
      sign_q_r    <= 1'b0;
      sign_r_r    <= 1'b0;
      dbz_r       <= 1'b0;
      cnt_r       <= '0;
      quotient_o  <= '0;
      remainder_o <= '0;
      dbz_o       <= 1'b0;
    end else begin
      case (state_r)
        eIdle: if (v_i) begin
          dvd_raw_r <= dividend_i;
          dvs_raw_r <= divisor_i;
          signed_r  <= signed_i;
        end
        ePre: begin
          quo_r    <= dvd_mag;
          dvs_r    <= dvs_mag;
          rem_r    <= '0;
          sign_q_r <= dvd_neg ^ dvs_neg;
          sign_r_r <= dvd_neg;
          dbz_r    <= (dvs_raw_r == '0);
          cnt_r    <= '0;
        end
        eCal: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          cnt_r <= cnt_r + cnt_w_lp'(1);
        end
        eFix: begin
          // Divide-by-zero follows RISC-V: all-ones quotient, dividend as remainder.
          if (dbz_r) begin
            quotient_o  <= '1;
            remainder_o <= dvd_raw_r;
            dbz_o       <= 1'b1;
          end else begin
            quotient_o  <= quo_fix;
            remainder_o <= rem_fix;
            dbz_o       <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o);

endmodule
